// File: rtl/menu_controle_if.sv
// rtl/menu_controle_if.sv - menu controller signal bundle: session control, buttons and menu status
interface menu_controle_if;
    logic       inicia_menu;
    logic [2:0] menu_sel;
    logic       botao_cima;
    logic       botao_baixo;
    logic       botao_enter;
    logic       press_enter;
    logic [2:0] cursor;
    logic [7:0] opcao;
    logic       menu_ativo;
    logic [2:0] db_estado;

    modport slave (
        input  inicia_menu,
        input  menu_sel,
        input  botao_cima,
        input  botao_baixo,
        input  botao_enter,
        output press_enter,
        output cursor,
        output opcao,
        output menu_ativo,
        output db_estado
    );

    modport master (
        output inicia_menu,
        output menu_sel,
        output botao_cima,
        output botao_baixo,
        output botao_enter,
        input  press_enter,
        input  cursor,
        input  opcao,
        input  menu_ativo,
        input  db_estado
    );
endinterface

// File: rtl/menu_controle.sv
// rtl/menu_controle.sv - menu navigation FSM with button edge detection, hold-off and wrapping cursor
module menu_controle #(
    parameter int DEBOUNCE = 1000
) (
    input  logic            clock,
    input  logic            reset,
    menu_controle_if.slave  bus
);
    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        CARREGA  = 3'd1,
        NAVEGA   = 3'd2,
        CONFIRMA = 3'd3,
        PRONTO   = 3'd4
    } estado_t;

    localparam int            HW   = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [HW-1:0] HOLD = HW'(DEBOUNCE);

    estado_t       r_estado, w_proximo;
    logic [2:0]    r_cursor, w_cursor;
    logic [3:0]    r_n, w_n, w_n_sel;
    logic [HW-1:0] r_holdoff, w_holdoff;
    logic          r_prev_cima, r_prev_baixo, r_prev_enter;
    logic          w_ed_cima, w_ed_baixo, w_ed_enter, w_aceita;
    logic [2:0]    w_ultimo;

    assign w_ed_cima  = bus.botao_cima  & ~r_prev_cima;
    assign w_ed_baixo = bus.botao_baixo & ~r_prev_baixo;
    assign w_ed_enter = bus.botao_enter & ~r_prev_enter;
    assign w_aceita   = (r_estado == NAVEGA) && (r_holdoff == '0)
                        && (w_ed_cima || w_ed_baixo || w_ed_enter);
    assign w_ultimo   = 3'(r_n - 4'd1);

    always_comb begin
        case (bus.menu_sel)
            3'd0, 3'd1: w_n_sel = 4'd4;
            3'd2, 3'd3: w_n_sel = 4'd8;
            3'd4:       w_n_sel = 4'd3;
            default:    w_n_sel = 4'd1;
        endcase
    end

    always_comb begin
        w_proximo = r_estado;
        w_cursor  = r_cursor;
        w_n       = r_n;
        w_holdoff = (r_holdoff != '0) ? r_holdoff - HW'(1) : r_holdoff;
        case (r_estado)
            OCIOSO: ;
            CARREGA: begin
                w_proximo = NAVEGA;
                w_cursor  = 3'd0;
                w_n       = w_n_sel;
                w_holdoff = '0;
            end
            NAVEGA: begin
                if (w_aceita) begin
                    w_holdoff = HOLD;
                    // enter wins over any simultaneous up/down edge
                    if (w_ed_enter)
                        w_proximo = CONFIRMA;
                    else if (w_ed_cima && !w_ed_baixo)
                        w_cursor = (r_cursor == w_ultimo) ? 3'd0 : r_cursor + 3'd1;
                    else if (w_ed_baixo && !w_ed_cima)
                        w_cursor = (r_cursor == 3'd0) ? w_ultimo : r_cursor - 3'd1;
                end
            end
            CONFIRMA: w_proximo = PRONTO;
            PRONTO:   ;
            default:  w_proximo = OCIOSO;
        endcase
        if (bus.inicia_menu)
            w_proximo = CARREGA;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado     <= OCIOSO;
            r_cursor     <= 3'd0;
            r_n          <= 4'd1;
            r_holdoff    <= '0;
            r_prev_cima  <= 1'b0;
            r_prev_baixo <= 1'b0;
            r_prev_enter <= 1'b0;
        end else begin
            r_estado     <= w_proximo;
            r_cursor     <= w_cursor;
            r_n          <= w_n;
            r_holdoff    <= w_holdoff;
            // loading in CARREGA and tracking elsewhere reduce to one copy of the level
            r_prev_cima  <= bus.botao_cima;
            r_prev_baixo <= bus.botao_baixo;
            r_prev_enter <= bus.botao_enter;
        end
    end

    assign bus.db_estado   = r_estado;
    assign bus.cursor      = r_cursor;
    assign bus.opcao       = (r_estado == OCIOSO) ? 8'd0 : (8'd1 << r_cursor);
    assign bus.press_enter = (r_estado == CONFIRMA);
    assign bus.menu_ativo  = (r_estado == NAVEGA);
endmodule
